// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// control-action codes and the default register-address width.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // One action per cycle, listed in priority order.
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_HOLD    = 3'd1,
    ACT_FLUSH   = 3'd2,
    ACT_STALL   = 3'd3,
    ACT_ADVANCE = 3'd4
  } ctrl_act_e;

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline stage tracking {rd, wen, load} of the instruction it holds.
// Writes to r0 are never recorded as writes.
module hazard_shadow_stage #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          bubble,
  input  logic [AW-1:0] d_rd,
  input  logic          d_wen,
  input  logic          d_load,
  output logic [AW-1:0] rd,
  output logic          wen,
  output logic          load
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd   <= '0;
      wen  <= 1'b0;
      load <= 1'b0;
    end else if (hold) begin
      rd   <= rd;
      wen  <= wen;
      load <= load;
    end else if (bubble) begin
      rd   <= '0;
      wen  <= 1'b0;
      load <= 1'b0;
    end else begin
      rd   <= d_rd;
      wen  <= d_wen & (d_rd != '0);
      load <= d_load;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/hold decisions, EX operand forwarding
// selects and perf counters. Forwarding is enabled by PIPE_HAZARD_CTRL_FORWARDING_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_load,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              idex_we,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_wen, mem_wen, wb_wen;
  logic              ex_load, mem_load, wb_load;
  logic              sh_hold, ex_bubble;
  ctrl_act_e         act;
  logic              hazard;
  logic              a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic              unused_bits;

  function automatic logic src_match(input logic use_s, input logic [REG_AW-1:0] addr,
                                     input logic [REG_AW-1:0] rd, input logic wen);
    return use_s && (addr != '0) && wen && (addr == rd);
  endfunction

  hazard_shadow_stage #(.AW(REG_AW)) u_ex (
    .clk(clk), .rst(rst), .hold(sh_hold), .bubble(ex_bubble),
    .d_rd(id_rd), .d_wen(id_wen), .d_load(id_load),
    .rd(ex_rd), .wen(ex_wen), .load(ex_load)
  );

  hazard_shadow_stage #(.AW(REG_AW)) u_mem (
    .clk(clk), .rst(rst), .hold(sh_hold), .bubble(1'b0),
    .d_rd(ex_rd), .d_wen(ex_wen), .d_load(ex_load),
    .rd(mem_rd), .wen(mem_wen), .load(mem_load)
  );

  hazard_shadow_stage #(.AW(REG_AW)) u_wb (
    .clk(clk), .rst(rst), .hold(sh_hold), .bubble(1'b0),
    .d_rd(mem_rd), .d_wen(mem_wen), .d_load(mem_load),
    .rd(wb_rd), .wen(wb_wen), .load(wb_load)
  );

  always_comb begin
    a_ex  = src_match(id_use_rs, id_rs, ex_rd,  ex_wen);
    a_mem = src_match(id_use_rs, id_rs, mem_rd, mem_wen);
    a_wb  = src_match(id_use_rs, id_rs, wb_rd,  wb_wen);
    b_ex  = src_match(id_use_rt, id_rt, ex_rd,  ex_wen);
    b_mem = src_match(id_use_rt, id_rt, mem_rd, mem_wen);
    b_wb  = src_match(id_use_rt, id_rt, wb_rd,  wb_wen);
  end

`ifdef PIPE_HAZARD_CTRL_FORWARDING_EN
  // Only a load still in EX cannot be bypassed; WB is assumed written through the RF.
  assign hazard      = ex_load & (a_ex | b_ex);
  assign unused_bits = ^{a_wb, b_wb, mem_load, wb_load, wb_rd, wb_wen};
`else
  assign hazard      = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
  assign unused_bits = ^{mem_load, wb_load};
`endif

  always_comb begin
    act = ACT_ADVANCE;
    if (rst)              act = ACT_RESET;
    else if (mem_busy)    act = ACT_HOLD;
    else if (ex_br_taken) act = ACT_FLUSH;
    else if (hazard)      act = ACT_STALL;
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_we     = 1'b1;
    sh_hold     = 1'b0;
    ex_bubble   = 1'b0;
    unique case (act)
      ACT_RESET: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      ACT_HOLD: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        sh_hold = 1'b1;
      end
      ACT_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        ex_bubble   = 1'b1;
      end
      ACT_STALL: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        ex_bubble   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (act == ACT_STALL && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else if (act == ACT_FLUSH && flush_cnt != '1) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

`ifdef PIPE_HAZARD_CTRL_FORWARDING_EN
  logic [1:0] fwd_a_id, fwd_b_id;
  logic [1:0] fwd_a_q, fwd_b_q;

  // EX is the youngest producer, so it wins over MEM.
  always_comb begin
    fwd_a_id = FWD_RF;
    fwd_b_id = FWD_RF;
    if (a_ex)       fwd_a_id = FWD_EXMEM;
    else if (a_mem) fwd_a_id = FWD_MEMWB;
    if (b_ex)       fwd_b_id = FWD_EXMEM;
    else if (b_mem) fwd_b_id = FWD_MEMWB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      unique case (act)
        ACT_ADVANCE: begin
          fwd_a_q <= fwd_a_id;
          fwd_b_q <= fwd_b_id;
        end
        ACT_FLUSH, ACT_STALL: begin
          fwd_a_q <= FWD_RF;
          fwd_b_q <= FWD_RF;
        end
        default: ;
      endcase
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues one directed vector per
// cycle and queues the expected outputs; a monitor compares on the falling edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] rd;
    logic       wen, ld, br, busy;
  } stim_t;

  typedef struct packed {
    logic [4:0]  ctl;  // {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we}
    logic [1:0]  fa, fb;
    logic [15:0] sc, fc;
  } exp_t;

  localparam logic [4:0] C_NORM  = 5'b11001;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_BUSY  = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b00111;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_wen, id_load, ex_br_taken, mem_busy;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, idex_we;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_we(idex_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic stim_t S(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] rd,
                              input logic wen, input logic ld, input logic br, input logic busy);
    S = '{rst: r, rs: rs, rt: rt, urs: urs, urt: urt, rd: rd, wen: wen, ld: ld, br: br, busy: busy};
  endfunction

  function automatic exp_t E(input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                             input int sc, input int fc);
    E = '{ctl: ctl, fa: fa, fb: fb, sc: sc[15:0], fc: fc[15:0]};
  endfunction

  task automatic step(input string nm, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.urs; id_use_rt = s.urt;
    id_rd = s.rd; id_wen = s.wen; id_load = s.ld; ex_br_taken = s.br; mem_busy = s.busy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every presented cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = '{ctl: {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we},
             fa: fwd_a, fb: fwd_b, sc: stall_cnt, fc: flush_cnt};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s: got ctl=%b fa=%b fb=%b stall=%0d flush=%0d, want ctl=%b fa=%b fb=%b stall=%0d flush=%0d",
                 nm, g.ctl, g.fa, g.fb, g.sc, g.fc, e.ctl, e.fa, e.fb, e.sc, e.fc);
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rd = '0; id_wen = 1'b0; id_load = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);

`ifdef PIPE_HAZARD_CTRL_FORWARDING_EN
    step("reset",       S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_RST,   2'b00, 2'b00, 0, 0));
    step("load_r3",     S(0, 0, 0, 0, 0, 3, 1, 1, 0, 0), E(C_NORM,  2'b00, 2'b00, 0, 0));
    step("load_use",    S(0, 3, 0, 1, 0, 0, 0, 0, 0, 0), E(C_STALL, 2'b00, 2'b00, 0, 0));
    step("after_stall", S(0, 3, 0, 1, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 0));
    step("fwd_memwb",   S(0, 0, 0, 0, 0, 5, 1, 0, 0, 0), E(C_NORM,  2'b10, 2'b00, 1, 0));
    step("alu_use_rt",  S(0, 0, 5, 0, 1, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 0));
    step("fwd_exmem",   S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), E(C_NORM,  2'b00, 2'b01, 1, 0));
    step("r0_read",     S(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 0));
    step("r0_fwd",      S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 0));
    step("load_r4",     S(0, 0, 0, 0, 0, 4, 1, 1, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 0));
    step("br_vs_stall", S(0, 4, 0, 1, 0, 0, 0, 0, 1, 0), E(C_FLUSH, 2'b00, 2'b00, 1, 0));
    step("after_flush", S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 1));
    for (int i = 0; i < 3; i++)
      step("busy_br",   S(0, 0, 0, 0, 0, 9, 1, 0, 1, 1), E(C_BUSY,  2'b00, 2'b00, 1, 1));
    step("br_release",  S(0, 0, 0, 0, 0, 9, 1, 0, 1, 0), E(C_FLUSH, 2'b00, 2'b00, 1, 1));
    step("after_br2",   S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 1, 2));
    step("rst_pulse",   S(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), E(C_RST,   2'b00, 2'b00, 1, 2));
    step("post_rst",    S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 0, 0));
`else
    step("reset",       S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_RST,   2'b00, 2'b00, 0, 0));
    step("alu_r7",      S(0, 0, 0, 0, 0, 7, 1, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 0, 0));
    step("raw_ex",      S(0, 7, 0, 1, 0, 0, 0, 0, 0, 0), E(C_STALL, 2'b00, 2'b00, 0, 0));
    step("raw_mem",     S(0, 7, 0, 1, 0, 0, 0, 0, 0, 0), E(C_STALL, 2'b00, 2'b00, 1, 0));
    step("raw_wb",      S(0, 7, 0, 1, 0, 0, 0, 0, 0, 0), E(C_STALL, 2'b00, 2'b00, 2, 0));
    step("raw_clear",   S(0, 7, 0, 1, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 0));
    step("r0_write",    S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 0));
    step("r0_read",     S(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 0));
    for (int i = 0; i < 3; i++)
      step("busy_br",   S(0, 0, 0, 0, 0, 9, 1, 0, 1, 1), E(C_BUSY,  2'b00, 2'b00, 3, 0));
    step("br_release",  S(0, 0, 0, 0, 0, 9, 1, 0, 1, 0), E(C_FLUSH, 2'b00, 2'b00, 3, 0));
    step("after_flush", S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 1));
    step("load_r4",     S(0, 0, 0, 0, 0, 4, 1, 1, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 1));
    step("br_vs_stall", S(0, 0, 4, 0, 1, 0, 0, 0, 1, 0), E(C_FLUSH, 2'b00, 2'b00, 3, 1));
    step("after_br2",   S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 2));
    step("alu_r6",      S(0, 0, 0, 0, 0, 6, 1, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 3, 2));
    step("raw_r6",      S(0, 6, 0, 1, 0, 0, 0, 0, 0, 0), E(C_STALL, 2'b00, 2'b00, 3, 2));
    step("rst_midstall",S(1, 6, 0, 1, 0, 0, 0, 0, 0, 0), E(C_RST,   2'b00, 2'b00, 4, 2));
    step("post_rst",    S(0, 6, 0, 1, 0, 0, 0, 0, 0, 0), E(C_NORM,  2'b00, 2'b00, 0, 0));
    step("rst_vs_busy", S(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), E(C_RST,   2'b00, 2'b00, 0, 0));
`endif

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
